// File: rtl/mmio_pkg.sv
// Shared definitions for the wait-state MMIO controller: FSM encoding,
// default geometry, error word and well-known slot indices.
package mmio_pkg;

  localparam int          SLOT_AW_DEF  = 6;
  localparam int          REG_AW_DEF   = 5;
  localparam logic [31:0] ERR_DATA_DEF = 32'hFFFF_FFFF;

  // Fixed slot assignments inside the MMIO subsystem
  localparam int SLOT_SYS_TIMER = 0;
  localparam int SLOT_UART      = 1;
  localparam int SLOT_LED       = 2;
  localparam int SLOT_SWITCH    = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mmio_timeout_cnt.sv
// Wait-cycle counter. expire is raised during the TIMEOUT-th enabled cycle
// after a clear, so the FSM spends exactly TIMEOUT cycles in WAIT before
// aborting.
module mmio_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign expire = en && (cnt == CW'(TIMEOUT - 1));

  // Count enabled cycles; clear has priority, stop once expired
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mmio_ctrl_ws.sv
// MMIO controller with wait states. A CPU request is latched in IDLE,
// the addressed slot is strobed for one cycle (ACCESS), the controller
// then waits for that slot's ready (WAIT) up to TIMEOUT cycles, and
// finally reports completion with a one-cycle mmio_ready (DONE).
//
// Handshake: the CPU raises mmio_cs with rd and/or wr and holds the request
// until it sees mmio_ready=1 for one cycle; mmio_rd_data is valid in that
// cycle. Towards a slot, slot_cs/slot_rd/slot_wr pulse for exactly one cycle
// and the slot answers with slot_ready in that cycle or any later one;
// ready bits of slots that are not selected are ignored.
import mmio_pkg::*;

module mmio_ctrl_ws #(
  parameter int                 N_SLOT       = 64,
  parameter int                 SLOT_AW      = SLOT_AW_DEF,
  parameter int                 REG_AW       = REG_AW_DEF,
  parameter int                 TIMEOUT      = 255,
  parameter logic [N_SLOT-1:0]  PRESENT_MASK = 'hF,
  parameter logic [31:0]        ERR_DATA     = ERR_DATA_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mmio_cs,
  input  logic                  mmio_wr,
  input  logic                  mmio_rd,
  input  logic [20:0]           mmio_addr,
  input  logic [31:0]           mmio_wr_data,
  output logic [31:0]           mmio_rd_data,
  output logic                  mmio_ready,
  output logic                  bus_err,
  output logic [7:0]            err_count,
  output logic [N_SLOT-1:0]     slot_cs,
  output logic [N_SLOT-1:0]     slot_rd,
  output logic [N_SLOT-1:0]     slot_wr,
  output logic [REG_AW-1:0]     slot_reg_addr,
  output logic [31:0]           slot_wr_data,
  input  logic [N_SLOT*32-1:0]  slot_rd_data,
  input  logic [N_SLOT-1:0]     slot_ready
);

  state_t              state, state_nx;

  logic [SLOT_AW-1:0]  sel;
  logic [REG_AW-1:0]   reg_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rd_data_q;
  logic                op_wr;
  logic                err_q;
  logic [7:0]          err_cnt;

  logic                req;
  logic [SLOT_AW-1:0]  req_slot;
  logic                req_present;
  logic                sel_ready;
  logic [31:0]         sel_rdata;
  logic [N_SLOT-1:0]   sel_oh;

  logic                cnt_clr;
  logic                cnt_en;
  logic                cnt_expire;
  logic                fin_ok;
  logic                fin_err;

  // Address bits above the slot field are don't-care
  logic                unused_addr_hi;
  assign unused_addr_hi = ^mmio_addr[20:REG_AW+SLOT_AW];

  assign req         = mmio_cs & (mmio_rd | mmio_wr);
  assign req_slot    = mmio_addr[REG_AW +: SLOT_AW];
  assign req_present = PRESENT_MASK[req_slot];
  assign sel_ready   = slot_ready[sel];
  assign sel_rdata   = slot_rd_data[{sel, 5'd0} +: 32];
  assign sel_oh      = {{(N_SLOT-1){1'b0}}, 1'b1} << sel;

  mmio_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expire (cnt_expire)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, counter control and completion qualifiers
  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    fin_ok   = 1'b0;
    fin_err  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req) begin
          if (req_present) begin
            state_nx = ST_ACCESS;
          end else begin
            state_nx = ST_DONE;
            fin_err  = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        cnt_clr = 1'b1;
        if (sel_ready) begin
          state_nx = ST_DONE;
          fin_ok   = 1'b1;
        end else begin
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_en = 1'b1;
        // A ready in the last allowed wait cycle still counts as success
        if (sel_ready) begin
          state_nx = ST_DONE;
          fin_ok   = 1'b1;
        end else if (cnt_expire) begin
          state_nx = ST_DONE;
          fin_err  = 1'b1;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Request latch, completion data and saturating error counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel       <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      op_wr     <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      err_cnt   <= '0;
    end else begin
      if (state == ST_IDLE && req) begin
        sel     <= req_slot;
        reg_q   <= mmio_addr[REG_AW-1:0];
        wdata_q <= mmio_wr_data;
        op_wr   <= mmio_wr;
      end
      if (fin_ok || fin_err) begin
        err_q <= fin_err;
      end
      if (fin_err) begin
        rd_data_q <= ERR_DATA;
      end else if (fin_ok && !op_wr) begin
        rd_data_q <= sel_rdata;
      end
      if (state == ST_DONE && err_q && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  // Write wins when both strobes are requested
  assign slot_cs       = (state == ST_ACCESS) ? sel_oh : '0;
  assign slot_wr       = (state == ST_ACCESS && op_wr) ? sel_oh : '0;
  assign slot_rd       = (state == ST_ACCESS && !op_wr) ? sel_oh : '0;
  assign slot_reg_addr = reg_q;
  assign slot_wr_data  = wdata_q;
  assign mmio_rd_data  = rd_data_q;
  assign mmio_ready    = (state == ST_DONE);
  assign bus_err       = (state == ST_DONE) && err_q;
  assign err_count     = err_cnt;

endmodule

// File: tb/tb_mmio_ctrl_ws.sv
// Bench for mmio_ctrl_ws with TIMEOUT=8 and slots 0..3 populated.
module tb_mmio_ctrl_ws;
  import mmio_pkg::*;

  localparam int          TO    = 8;
  localparam int          NS    = 64;
  localparam logic [63:0] PMASK = 64'h0000_0000_0000_000F;
  localparam logic [31:0] ERRW  = 32'hFFFF_FFFF;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             mmio_cs = 1'b0, mmio_wr = 1'b0, mmio_rd = 1'b0;
  logic [20:0]      mmio_addr = '0;
  logic [31:0]      mmio_wr_data = '0;
  logic [31:0]      mmio_rd_data;
  logic             mmio_ready, bus_err;
  logic [7:0]       err_count;
  logic [NS-1:0]    slot_cs, slot_rd, slot_wr;
  logic [4:0]       slot_reg_addr;
  logic [31:0]      slot_wr_data;
  logic [NS*32-1:0] slot_rd_data = '0;
  logic [NS-1:0]    slot_ready = '0;

  mmio_ctrl_ws #(
    .N_SLOT(NS), .SLOT_AW(6), .REG_AW(5), .TIMEOUT(TO),
    .PRESENT_MASK(PMASK), .ERR_DATA(ERRW)
  ) dut (
    .clk(clk), .reset(rst),
    .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_data(mmio_rd_data), .mmio_ready(mmio_ready),
    .bus_err(bus_err), .err_count(err_count),
    .slot_cs(slot_cs), .slot_rd(slot_rd), .slot_wr(slot_wr),
    .slot_reg_addr(slot_reg_addr), .slot_wr_data(slot_wr_data),
    .slot_rd_data(slot_rd_data), .slot_ready(slot_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] onehot(input int s);
    return 64'd1 << s;
  endfunction

  typedef struct {
    logic        rd;
    logic        wr;
    logic [9:0]  hi;
    logic [5:0]  slot;
    logic [4:0]  rg;
    logic [31:0] wdata;
    int          k;        // wait cycles before ready, -1 = never
    logic        noise;    // raise ready on every other slot
    logic [31:0] rdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_data;
  } vec_t;

  // scoreboard: {rd_data, bus_err, latency}
  logic [40:0] exp_q[$];
  int          req_cyc = 0;
  int          model_err = 0;

  // slot responder state (set by the driver, used by the monitor)
  int          resp_slot = 0;
  int          resp_k = 0;
  logic        resp_wr = 1'b0;
  logic [4:0]  resp_reg = '0;
  logic [31:0] resp_wdata = '0;
  logic [63:0] extra_ready = '0;
  logic        mon_en = 1'b0;

  int          strobe_cnt = 0;
  int          wcnt = 0;
  logic        waiting = 1'b0;
  logic        ready_now;
  logic [63:0] m_oh;
  logic [40:0] m_e;

  // monitor + slot responder, sampling on the falling edge
  always @(negedge clk) begin
    ready_now = 1'b0;
    m_oh = onehot(resp_slot);
    if (rst) begin
      waiting = 1'b0;
    end else if (mon_en) begin
      if (|slot_cs) begin
        strobe_cnt++;
        check("slot_cs", slot_cs, m_oh);
        check("slot_wr", slot_wr, resp_wr ? m_oh : 64'd0);
        check("slot_rd", slot_rd, resp_wr ? 64'd0 : m_oh);
        check("slot_reg_addr", slot_reg_addr, resp_reg);
        check("slot_wr_data", slot_wr_data, resp_wdata);
        if (resp_k == 0) ready_now = 1'b1;
        else begin waiting = 1'b1; wcnt = resp_k; end
      end else if (waiting) begin
        check("wait_strobes", slot_rd | slot_wr, 64'd0);
        check("wait_reg_addr", slot_reg_addr, resp_reg);
        check("wait_wr_data", slot_wr_data, resp_wdata);
        if (wcnt > 0) begin
          wcnt--;
          if (wcnt == 0) begin ready_now = 1'b1; waiting = 1'b0; end
        end
      end
      if (mmio_ready) begin
        waiting = 1'b0;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready: got ready at cycle %0d expected none", cyc);
        end else begin
          m_e = exp_q.pop_front();
          check("rd_data", mmio_rd_data, m_e[40:9]);
          check("bus_err", bus_err, m_e[8]);
          check("latency", cyc - req_cyc + 1, m_e[7:0]);
        end
      end else begin
        check("bus_err_idle", bus_err, 1'b0);
      end
    end
    slot_ready = (ready_now ? m_oh : 64'd0) | extra_ready;
  end

  // driver: issue one CPU access and hold it until mmio_ready
  task automatic do_access(input vec_t v);
    int   base;
    logic seen;
    @(negedge clk);
    resp_slot  = v.slot;
    resp_k     = v.k;
    resp_wr    = v.wr;
    resp_reg   = v.rg;
    resp_wdata = v.wdata;
    extra_ready = v.noise ? ~onehot(v.slot) : 64'd0;
    for (int i = 0; i < NS; i++) slot_rd_data[32*i +: 32] = $urandom;
    slot_rd_data[32*int'(v.slot) +: 32] = v.rdata;
    mmio_cs = 1'b1; mmio_rd = v.rd; mmio_wr = v.wr;
    mmio_addr = {v.hi, v.slot, v.rg};
    mmio_wr_data = v.wdata;
    exp_q.push_back({v.exp_data, v.exp_err, 8'(v.exp_lat)});
    req_cyc = cyc;
    base = strobe_cnt;
    if (v.exp_err && model_err < 255) model_err++;
    seen = 1'b0;
    for (int c = 0; c < 64 && !seen; c++) begin
      @(negedge clk);
      if (mmio_ready) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL access_done: got no ready expected ready (slot %0d)", v.slot);
    end
    mmio_cs = 1'b0; mmio_rd = 1'b0; mmio_wr = 1'b0;
    check("strobe_count", strobe_cnt - base, PMASK[v.slot] ? 1 : 0);
    @(negedge clk);
    check("err_count", err_count, model_err);
    extra_ready = '0;
  endtask

  vec_t vecs[10];
  vec_t v;
  int   nready;

  initial begin
    //               rd    wr    hi      slot rg     wdata          k   noise rdata          err  lat exp_data
    vecs[0] = '{1'b1, 1'b0, 10'h0,   6'd3,  5'd2,  32'h0,         0, 1'b0, 32'h1234_5678, 1'b0, 3,  32'h1234_5678};
    vecs[1] = '{1'b0, 1'b1, 10'h0,   6'd2,  5'd0,  32'hA5,        4, 1'b1, 32'h0BAD_0BAD, 1'b0, 7,  32'h1234_5678};
    vecs[2] = '{1'b1, 1'b0, 10'h0,   6'd40, 5'd0,  32'h0,         0, 1'b0, 32'h0,         1'b1, 2,  ERRW};
    vecs[3] = '{1'b1, 1'b0, 10'h0,   6'd1,  5'd4,  32'h0,        -1, 1'b1, 32'h1111,      1'b1, 11, ERRW};
    vecs[4] = '{1'b1, 1'b1, 10'h0,   6'd0,  5'd7,  32'hDEAD_BEEF, 1, 1'b0, 32'h0BAD,      1'b0, 4,  ERRW};
    vecs[5] = '{1'b1, 1'b0, 10'h0,   6'd0,  5'd31, 32'h0,         2, 1'b1, 32'hCAFE_F00D, 1'b0, 5,  32'hCAFE_F00D};
    vecs[6] = '{1'b1, 1'b0, 10'h0,   6'd2,  5'd9,  32'h0,         8, 1'b0, 32'h55AA,      1'b0, 11, 32'h55AA};
    vecs[7] = '{1'b1, 1'b0, 10'h0,   6'd63, 5'd1,  32'h77,        0, 1'b0, 32'h0,         1'b1, 2,  ERRW};
    vecs[8] = '{1'b1, 1'b0, 10'h0,   6'd1,  5'd17, 32'h3C3C,      7, 1'b1, 32'h77,        1'b0, 10, 32'h77};
    vecs[9] = '{1'b1, 1'b0, 10'h3FF, 6'd3,  5'd1,  32'h0,         0, 1'b0, 32'h99,        1'b0, 3,  32'h99};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_slot_cs", slot_cs, 64'd0);
    check("rst_slot_rd", slot_rd, 64'd0);
    check("rst_slot_wr", slot_wr, 64'd0);
    check("rst_ready", mmio_ready, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_rd_data", mmio_rd_data, 32'd0);
    check("rst_reg_addr", slot_reg_addr, 5'd0);
    check("rst_wr_data", slot_wr_data, 32'd0);
    check("rst_err_count", err_count, 8'd0);
    #2 rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) do_access(vecs[i]);

    // late ready on slot 1 after its timeout must not do anything
    nready = 0;
    extra_ready = onehot(1);
    repeat (5) begin
      @(negedge clk);
      if (mmio_ready || bus_err) nready++;
    end
    extra_ready = '0;
    check("late_ready", nready, 0);
    check("late_err_count", err_count, model_err);

    // err_count saturation with unmapped reads
    for (int i = 0; i < 300; i++) begin
      v = '{1'b1, 1'b0, 10'($urandom), 6'($urandom_range(4, 63)), 5'($urandom),
            32'($urandom), 0, 1'b0, 32'h0, 1'b1, 2, ERRW};
      do_access(v);
    end
    check("err_sat", err_count, 8'd255);

    // reset in the middle of WAIT
    @(negedge clk);
    resp_slot = 1; resp_k = -1; resp_wr = 1'b0; resp_reg = 5'd6; resp_wdata = 32'h5151;
    mmio_cs = 1'b1; mmio_rd = 1'b1; mmio_wr = 1'b0;
    mmio_addr = {10'h0, 6'd1, 5'd6}; mmio_wr_data = 32'h5151;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_cs", slot_cs, 64'd0);
    check("mid_rst_ready", mmio_ready, 1'b0);
    check("mid_rst_bus_err", bus_err, 1'b0);
    check("mid_rst_err_count", err_count, 8'd0);
    check("mid_rst_rd_data", mmio_rd_data, 32'd0);
    mmio_cs = 1'b0; mmio_rd = 1'b0;
    model_err = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    v = '{1'b1, 1'b0, 10'h0, 6'd3, 5'd5, 32'h0, 0, 1'b0, 32'h0F0F_1234, 1'b0, 3, 32'h0F0F_1234};
    do_access(v);
    v = '{1'b0, 1'b1, 10'h0, 6'd1, 5'd3, 32'h8181, 3, 1'b1, 32'h0, 1'b0, 6, 32'h0F0F_1234};
    do_access(v);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    errors++;
    $display("FAIL watchdog: got no end of test expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
